// File: rtl/tcdm_rr_arbiter_if.sv
// Bundle of TCDM request/response signals for N ports.
// The arbiter uses one instance with N = NR on its master-facing side and one with N = 1 on
// its slave-facing side.
//   req/gnt      request / grant handshake, one bit per port
//   add/wen/be   address, write-enable-n (1 = read), byte enable
//   data         write data
//   r_data       response data
//   r_valid      response valid
// Modport master: the side issuing requests. Modport slave: the side accepting them.
interface tcdm_rr_arbiter_if #(
    parameter int unsigned N  = 1,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [N-1:0]              req;
    logic [N-1:0]              gnt;
    logic [N-1:0][AW-1:0]      add;
    logic [N-1:0]              wen;
    logic [N-1:0][DW/8-1:0]    be;
    logic [N-1:0][DW-1:0]      data;
    logic [N-1:0][DW-1:0]      r_data;
    logic [N-1:0]              r_valid;

    modport master (
        output req, add, wen, be, data,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, add, wen, be, data,
        output gnt, r_data, r_valid
    );
endinterface

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM slave port between NR TCDM masters.
// Outstanding transactions are tracked in an in-order ID FIFO so every slave response is
// routed back to the master that issued it.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous reset, active low
//   in_bus   NR master ports (slave modport: requests come in, grants/responses go out)
//   out_bus  single slave port (master modport)
//   err_o    sticky flag: slave response arrived with nothing outstanding
module tcdm_rr_arbiter #(
    parameter int unsigned NR      = 3,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    tcdm_rr_arbiter_if.slave  in_bus,
    tcdm_rr_arbiter_if.master out_bus,
    output logic              err_o
);
    localparam int unsigned IdW  = (NR > 1) ? $clog2(NR) : 1;
    localparam int unsigned CntW = $clog2(MAX_OUT + 1);

    typedef logic [IdW-1:0] id_t;

    id_t                         rr_ptr_q, rr_ptr_d;
    logic                        lock_vld_q, lock_vld_d;
    id_t                         lock_id_q, lock_id_d;
    logic [MAX_OUT-1:0][IdW-1:0] fifo_q, fifo_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic                        err_q, err_d;

    id_t             winner, winner_inc, scan_id;
    int unsigned     scan_idx;
    logic            found, any_req, fifo_full, out_req, hs, pop;
    logic [CntW-1:0] wr_idx;

    // Winner selection: a stalled request keeps the port, otherwise scan from rr_ptr.
    always_comb begin
        winner   = rr_ptr_q;
        found    = 1'b0;
        scan_idx = 0;
        scan_id  = '0;
        for (int k = 0; k < NR; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NR) scan_idx = scan_idx - NR;
            scan_id = id_t'(scan_idx);
            if (!found && in_bus.req[scan_id]) begin
                winner = scan_id;
                found  = 1'b1;
            end
        end
        if (lock_vld_q) winner = lock_id_q;
        winner_inc = (winner == id_t'(NR - 1)) ? '0 : winner + id_t'(1);
    end

    assign any_req   = |in_bus.req;
    assign fifo_full = (cnt_q == CntW'(MAX_OUT));
    assign out_req   = any_req & ~fifo_full;
    assign hs        = out_req & out_bus.gnt[0];
    assign pop       = out_bus.r_valid[0] & (cnt_q != '0);

    // Request mux, zero-cycle grant and response routing.
    always_comb begin
        out_bus.req[0]  = out_req;
        out_bus.add[0]  = '0;
        out_bus.wen[0]  = 1'b0;
        out_bus.be[0]   = '0;
        out_bus.data[0] = '0;
        if (any_req) begin
            out_bus.add[0]  = in_bus.add[winner];
            out_bus.wen[0]  = in_bus.wen[winner];
            out_bus.be[0]   = in_bus.be[winner];
            out_bus.data[0] = in_bus.data[winner];
        end
        in_bus.gnt = '0;
        if (hs) in_bus.gnt[winner] = 1'b1;
        in_bus.r_valid = '0;
        if (pop) in_bus.r_valid[fifo_q[0]] = 1'b1;
        for (int i = 0; i < NR; i++) in_bus.r_data[i] = out_bus.r_data[0];
    end

    // Next state: pointer, lock, ID FIFO (head at index 0) and error flag.
    always_comb begin
        rr_ptr_d   = hs ? winner_inc : rr_ptr_q;
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        if (hs) begin
            lock_vld_d = 1'b0;
        end else if (out_req) begin
            lock_vld_d = 1'b1;
            lock_id_d  = winner;
        end

        fifo_d = fifo_q;
        cnt_d  = cnt_q;
        wr_idx = cnt_q;
        if (pop) begin
            for (int i = 0; i < MAX_OUT - 1; i++) fifo_d[i] = fifo_q[i+1];
            wr_idx = cnt_q - CntW'(1);
        end
        // Push lands behind the surviving entries, so a same-cycle pop keeps order.
        if (hs) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                if (CntW'(i) == wr_idx) fifo_d[i] = winner;
            end
        end
        if (hs && !pop) cnt_d = cnt_q + CntW'(1);
        else if (!hs && pop) cnt_d = cnt_q - CntW'(1);

        err_d = err_q | (out_bus.r_valid[0] & (cnt_q == '0));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= '0;
            fifo_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            fifo_q     <= fifo_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign err_o = err_q;
endmodule
